// File: rtl/tag_issuer_1rd.sv
// Read-request tag issuer: allocates tags from a free pool, issues tagged
// requests downstream and releases tags in issue order on done_i.
module tag_issuer_1rd #(
    parameter int TAG_WIDTH = 2,
    parameter int REQ_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [REQ_WIDTH-1:0] req_bi,
    output logic                 req_ack_o,
    output logic                 rd_o,
    output logic [REQ_WIDTH-1:0] rdreq_bo,
    output logic [TAG_WIDTH-1:0] rdtag_o,
    input  logic                 rd_ack_i,
    input  logic                 tag_fifo_full,
    output logic                 tag_fifo_wrreq,
    output logic [TAG_WIDTH-1:0] tag_fifo_wdata,
    input  logic                 done_i,
    output logic [TAG_WIDTH:0]   outstanding_o,
    output logic                 err_o
);

    localparam int N = 1 << TAG_WIDTH;

    logic [N-1:0]         r_free;
    logic                 r_rd;
    logic [REQ_WIDTH-1:0] r_rdreq;
    logic [TAG_WIDTH-1:0] r_rdtag;
    logic [TAG_WIDTH-1:0] r_q [N];
    logic [TAG_WIDTH-1:0] r_wptr;
    logic [TAG_WIDTH-1:0] r_rptr;
    logic [TAG_WIDTH:0]   r_cnt;
    logic                 r_err;

    logic [N-1:0]         w_free_nxt;
    logic [TAG_WIDTH-1:0] w_tag;
    logic [TAG_WIDTH-1:0] w_rel_tag;
    logic                 w_slot_free;
    logic                 w_accept;
    logic                 w_done;

    // Lowest set bit of the registered pool wins.
    always_comb begin
        w_tag = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_free[i]) w_tag = TAG_WIDTH'(i);
        end
    end

    assign w_slot_free = !r_rd || rd_ack_i;
    assign w_accept    = req_i && (|r_free) && !tag_fifo_full && w_slot_free;
    assign w_done      = done_i && (r_cnt != '0);
    assign w_rel_tag   = r_q[r_rptr];

    // Released tag is never the one being allocated: it is not yet free.
    always_comb begin
        w_free_nxt = r_free;
        if (w_accept) w_free_nxt[w_tag] = 1'b0;
        if (w_done) w_free_nxt[w_rel_tag] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_free  <= '1;
            r_rd    <= 1'b0;
            r_rdreq <= '0;
            r_rdtag <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < N; i++) r_q[i] <= '0;
        end else begin
            r_free <= w_free_nxt;
            if (w_accept) begin
                r_rd         <= 1'b1;
                r_rdreq      <= req_bi;
                r_rdtag      <= w_tag;
                r_q[r_wptr]  <= w_tag;
                r_wptr       <= r_wptr + TAG_WIDTH'(1);
            end else if (rd_ack_i) begin
                r_rd <= 1'b0;
            end
            if (w_done) r_rptr <= r_rptr + TAG_WIDTH'(1);
            if (w_accept && !w_done) begin
                r_cnt <= r_cnt + (TAG_WIDTH+1)'(1);
            end else if (!w_accept && w_done) begin
                r_cnt <= r_cnt - (TAG_WIDTH+1)'(1);
            end
            if (done_i && (r_cnt == '0)) r_err <= 1'b1;
        end
    end

    assign req_ack_o      = w_accept;
    assign tag_fifo_wrreq = w_accept;
    assign tag_fifo_wdata = w_tag;
    assign rd_o           = r_rd;
    assign rdreq_bo       = r_rdreq;
    assign rdtag_o        = r_rdtag;
    assign outstanding_o  = r_cnt;
    assign err_o          = r_err;

endmodule

// File: tb/tb_tag_issuer_1rd.sv
// Scoreboard bench for tag_issuer_1rd: directed vectors push expected
// {payload,tag} items; a monitor pops them on each downstream handshake.
module tb_tag_issuer_1rd;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] req_bi = '0;
    logic        req_ack_o;
    logic        rd_o;
    logic [31:0] rdreq_bo;
    logic [1:0]  rdtag_o;
    logic        rd_ack_i = 1'b0;
    logic        tag_fifo_full = 1'b0;
    logic        tag_fifo_wrreq;
    logic [1:0]  tag_fifo_wdata;
    logic        done_i = 1'b0;
    logic [2:0]  outstanding_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    logic [33:0] sb[$];

    tag_issuer_1rd #(.TAG_WIDTH(2), .REQ_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req_i), .req_bi(req_bi), .req_ack_o(req_ack_o),
        .rd_o(rd_o), .rdreq_bo(rdreq_bo), .rdtag_o(rdtag_o),
        .rd_ack_i(rd_ack_i), .tag_fifo_full(tag_fifo_full),
        .tag_fifo_wrreq(tag_fifo_wrreq), .tag_fifo_wdata(tag_fifo_wdata),
        .done_i(done_i), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs 1 unit after the falling edge; return at +2.
    task automatic step(input logic rq, input logic [31:0] d,
                        input logic ack, input logic full,
                        input logic dn);
        @(negedge clk_i);
        #1;
        req_i = rq; req_bi = d; rd_ack_i = ack;
        tag_fifo_full = full; done_i = dn;
        #1;
    endtask

    task automatic issue(input string nm, input logic [31:0] d,
                         input logic [1:0] tag);
        step(1'b1, d, 1'b1, 1'b0, 1'b0);
        chk({nm, "_ack"}, 64'(req_ack_o), 64'd1);
        chk({nm, "_tag"}, 64'(tag_fifo_wdata), 64'(tag));
        sb.push_back({d, tag});
    endtask

    // Monitor: a handshake happens at the coming rising edge.
    initial begin
        forever begin
            @(negedge clk_i);
            #3;
            if (rst_i && rd_o && rd_ack_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_empty: got req %0h tag %0d expected none",
                             rdreq_bo, rdtag_o);
                end else begin
                    logic [33:0] e;
                    e = sb.pop_front();
                    if ({rdreq_bo, rdtag_o} !== e) begin
                        errors++;
                        $display("FAIL mon_item: got %0h/%0d expected %0h/%0d",
                                 rdreq_bo, rdtag_o, e[33:2], e[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_rd", 64'(rd_o), 64'd0);
        chk("rst_req", 64'(rdreq_bo), 64'd0);
        chk("rst_tag", 64'(rdtag_o), 64'd0);
        chk("rst_out", 64'(outstanding_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        #1 rst_i = 1'b1;

        // Back-to-back fill
        issue("fill0", 32'hA0, 2'd0);
        issue("fill1", 32'hA1, 2'd1);
        issue("fill2", 32'hA2, 2'd2);
        issue("fill3", 32'hA3, 2'd3);
        step(1'b1, 32'hA4, 1'b1, 1'b0, 1'b0);
        chk("full_ack", 64'(req_ack_o), 64'd0);
        chk("full_wr", 64'(tag_fifo_wrreq), 64'd0);
        chk("full_out", 64'(outstanding_o), 64'd4);

        // Release tag 0 and reuse it one cycle later
        step(1'b1, 32'hA4, 1'b1, 1'b0, 1'b1);
        chk("rel_ack0", 64'(req_ack_o), 64'd0);
        step(1'b1, 32'hA4, 1'b1, 1'b0, 1'b0);
        chk("rel_out", 64'(outstanding_o), 64'd3);
        chk("reuse_ack", 64'(req_ack_o), 64'd1);
        chk("reuse_tag", 64'(tag_fifo_wdata), 64'd0);
        sb.push_back({32'hA4, 2'd0});
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_out", 64'(outstanding_o), 64'd0);
        chk("drain_err", 64'(err_o), 64'd0);

        // Downstream stall
        issue("st0", 32'hB0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
            chk("st_ack", 64'(req_ack_o), 64'd0);
            chk("st_rd", 64'(rd_o), 64'd1);
            chk("st_req", 64'(rdreq_bo), 64'hB0);
            chk("st_tag", 64'(rdtag_o), 64'd0);
        end
        issue("st1", 32'hB1, 2'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("st_out", 64'(outstanding_o), 64'd2);

        // Accept and release together: tag 2 in, tag 0 out
        step(1'b1, 32'hC0, 1'b1, 1'b0, 1'b1);
        chk("sim_ack", 64'(req_ack_o), 64'd1);
        chk("sim_tag", 64'(tag_fifo_wdata), 64'd2);
        sb.push_back({32'hC0, 2'd2});
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("sim_out", 64'(outstanding_o), 64'd2);

        // Tag FIFO backpressure; free tags are now 0 and 3
        step(1'b1, 32'hD0, 1'b1, 1'b1, 1'b0);
        chk("bp_ack", 64'(req_ack_o), 64'd0);
        chk("bp_wr", 64'(tag_fifo_wrreq), 64'd0);
        step(1'b1, 32'hD0, 1'b1, 1'b0, 1'b0);
        chk("bp_out", 64'(outstanding_o), 64'd2);
        chk("bp_ack1", 64'(req_ack_o), 64'd1);
        chk("bp_tag", 64'(tag_fifo_wdata), 64'd0);
        sb.push_back({32'hD0, 2'd0});

        // Spurious done with nothing outstanding
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("err_pre_out", 64'(outstanding_o), 64'd0);
        chk("err_pre", 64'(err_o), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("err_set", 64'(err_o), 64'd1);
        chk("err_out", 64'(outstanding_o), 64'd0);

        // Async reset with a pending request
        issue("ar0", 32'hE0, 2'd0);
        issue("ar1", 32'hE1, 2'd1);
        issue("ar2", 32'hE2, 2'd2);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("ar_pre_rd", 64'(rd_o), 64'd1);
        chk("ar_pre_out", 64'(outstanding_o), 64'd3);
        void'(sb.pop_back());
        #1 rst_i = 1'b0;
        #1;
        chk("ar_rd", 64'(rd_o), 64'd0);
        chk("ar_out", 64'(outstanding_o), 64'd0);
        chk("ar_err", 64'(err_o), 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        issue("ar_first", 32'hF0, 2'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
